// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer sharing one 64-bit memory port between the
// I-side walker, D-side walker and core data path, with stall timeout.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [63:0] i_addr,
  output logic        i_done,
  input  logic        d_req,
  input  logic [63:0] d_addr,
  output logic        d_done,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [63:0] c_addr,
  input  logic [63:0] c_wdata,
  output logic        c_done,
  output logic [63:0] rdata,
  output logic        err,
  output logic [1:0]  gnt_id,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_stall
);

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = 16;
  localparam int unsigned IW = 2;
  localparam logic [IW-1:0] ID_I    = 2'd0;
  localparam logic [IW-1:0] ID_D    = 2'd1;
  localparam logic [IW-1:0] ID_C    = 2'd2;
  localparam logic [IW-1:0] ID_NONE = 2'd3;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          i_done_q, i_done_d;
  logic          d_done_q, d_done_d;
  logic          c_done_q, c_done_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d;
  logic          mem_ren_q, mem_ren_d;
  logic          mem_wen_q, mem_wen_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic [2:0]    req_vec;
  logic          win_vld;
  logic [IW-1:0] win_id;
  logic          timeout_hit;
  int unsigned   idx;

  // A requester whose done pulse is high this cycle is not re-granted yet.
  assign req_vec = {c_req & ~c_done_q, d_req & ~d_done_q, i_req & ~i_done_q};

  // Round-robin pick starting after the last granted id.
  always_comb begin
    win_vld = 1'b0;
    win_id  = ID_NONE;
    idx     = 0;
    for (int unsigned k = 1; k <= 3; k++) begin
      idx = (32'(last_q) + k) % 32'd3;
      if (!win_vld && req_vec[idx]) begin
        win_vld = 1'b1;
        win_id  = IW'(idx);
      end
    end
  end

  assign timeout_hit = mem_stall && (TIMEOUT != 0) &&
                       ((cnt_q + CW'(1)) == CW'(TIMEOUT));

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    c_done_d    = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    gnt_id_d    = gnt_id_q;
    mem_ren_d   = mem_ren_q;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d  = BUSY;
          last_d   = win_id;
          gnt_id_d = win_id;
          cnt_d    = '0;
          case (win_id)
            ID_I: begin
              mem_addr_d = i_addr;
              mem_ren_d  = 1'b1;
              mem_wen_d  = 1'b0;
            end
            ID_D: begin
              mem_addr_d = d_addr;
              mem_ren_d  = 1'b1;
              mem_wen_d  = 1'b0;
            end
            default: begin
              mem_addr_d  = c_addr;
              mem_wdata_d = c_wdata;
              mem_ren_d   = ~c_we;
              mem_wen_d   = c_we;
            end
          endcase
        end
      end
      BUSY: begin
        if (!mem_stall || timeout_hit) begin
          rdata_d   = (!timeout_hit && mem_ren_q) ? mem_rdata : '0;
          err_d     = timeout_hit;
          i_done_d  = (gnt_id_q == ID_I);
          d_done_d  = (gnt_id_q == ID_D);
          c_done_d  = (gnt_id_q == ID_C);
          mem_ren_d = 1'b0;
          mem_wen_d = 1'b0;
          gnt_id_d  = ID_NONE;
          state_d   = IDLE;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_q      <= ID_C;
      cnt_q       <= '0;
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      c_done_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      gnt_id_q    <= ID_NONE;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      i_done_q    <= i_done_d;
      d_done_q    <= d_done_d;
      c_done_q    <= c_done_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      gnt_id_q    <= gnt_id_d;
      mem_ren_q   <= mem_ren_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign c_done    = c_done_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign gnt_id    = gnt_id_q;
  assign mem_ren   = mem_ren_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Three-way arbiter and sequencer for the single 64-bit memory read/write port shared by the instruction-side page-table walker, the data-side page-table walker and the core data access path. It grants one requester at a time using round-robin order and holds the port until the memory finishes (mem_stall low). It returns read data with a one-cycle done pulse and aborts a hung transaction after a programmable timeout.

## Interface
Parameters:
- TIMEOUT, 255: stalled BUSY cycles tolerated before forced completion with error; 0 disables the timeout. Counter is 16 bits wide.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- i_req  in  1  I-side walker request; held high with i_addr stable until i_done
- i_addr  in  64  I-side read address
- i_done  out  1  one-cycle completion pulse for I-side
- d_req  in  1  D-side walker request, same rules as i_req
- d_addr  in  64  D-side read address
- d_done  out  1  completion pulse for D-side
- c_req  in  1  core data request, same rules
- c_we  in  1  core write enable (1 = write, 0 = read)
- c_addr  in  64  core address
- c_wdata  in  64  core write data
- c_done  out  1  completion pulse for core
- rdata  out  64  read data, valid in the cycle a done pulse is high
- err  out  1  timeout flag, valid only with a done pulse
- gnt_id  out  2  current owner: 0 = I, 1 = D, 2 = core, 3 = none
- mem_ren  out  1  memory read enable
- mem_wen  out  1  memory write enable
- mem_addr  out  64  memory address
- mem_wdata  out  64  memory write data
- mem_rdata  in  64  memory read data, valid when mem_stall = 0
- mem_stall  in  1  high while the memory transaction is in progress

## Operation
- Two states: IDLE and BUSY.
- IDLE:
  - Sample the requests. A request whose own done is high this cycle is masked out.
  - If any request remains, pick the winner in round-robin order starting from last+1 (mod 3). `last` is the most recently granted id.
  - On a grant, latch the winner's address into mem_addr. For the core, also latch c_wdata into mem_wdata.
  - Drive mem_wen = c_we for the core, mem_ren = !c_we for the core; walkers always use mem_ren = 1.
  - Set gnt_id and last to the winner, clear the timeout counter, and go to BUSY.
- BUSY:
  - mem_addr, mem_wdata, mem_ren and mem_wen stay constant.
  - Requests from other requesters are not sampled.
  - Normal completion: on an edge with mem_stall = 0:
    - rdata <= mem_rdata for a read; rdata <= 0 for a write.
    - err <= 0.
    - Owner's done <= 1.
    - mem_ren and mem_wen <= 0, gnt_id <= 3, state <= IDLE.
  - Stall with timeout: on an edge with mem_stall = 1 and TIMEOUT != 0, the counter increments. When the counter reaches TIMEOUT:
    - Complete the same way as normal completion, but with rdata <= 0 and err <= 1.
    - The memory port is released regardless of mem_stall.
- Done pulses last exactly one cycle. err and rdata hold their values until the next completion.
- Requester contract: keep req high until its done pulse is seen, and drop req in the done cycle. A req still high after the done cycle is treated as a new request.
- Changing the address of a granted request while BUSY has no effect.
- Reset:
  - state = IDLE, last = 2 (so the first arbitration order is I, D, core), counter = 0.
  - All done pulses, err, mem_ren and mem_wen = 0; rdata, mem_addr and mem_wdata = 0; gnt_id = 3.
  - Reset asserted mid-BUSY abandons the transaction with no done pulse.

## Timing
- Request high before edge E0 in IDLE: from E0, mem_ren (or mem_wen) = 1 and gnt_id is valid.
- Memory with mem_stall = 0 at E1: done and rdata are high/valid during the E1 to E2 cycle. Minimum latency is 2 edges.
- Each stalled edge adds one cycle.
- The port idles for one cycle between transactions. The next grant, to another requester or to a re-raised request, comes no earlier than E2.
- With TIMEOUT = N and mem_stall stuck high: the done pulse follows N stalled edges after entering BUSY, i.e. the owner sees done + err at edge E0 + N.
- Simultaneous requests are resolved in a single IDLE cycle, with no combinational path from req to mem_*. All outputs are registered.

## Test plan
- Reset, i_req = 1, i_addr = 0x8000_1000, mem_stall = 0, mem_rdata = 0xABCD -> mem_ren = 1 and mem_addr = 0x8000_1000 after E0; i_done = 1 and rdata = 0xABCD after E1; gnt_id = 3 after E1.
- i_req, d_req and c_req all held high for three transactions -> grant order I, D, core; each done is one cycle; gnt_id sequence 0, 3, 1, 3, 2, 3.
- Core write c_we = 1, c_addr = 0x100, c_wdata = 0x55, mem_stall high for 3 edges -> mem_wen = 1 and mem_ren = 0 throughout; c_done comes 4 edges after the grant; rdata = 0.
- TIMEOUT = 4, d_req with mem_stall stuck at 1 -> d_done = 1 and err = 1 at E0 + 4; mem_ren drops at that edge; next c_req is granted at the following edge.
- rst = 0 asserted during BUSY, then released -> no done pulse; gnt_id = 3; first grant after reset goes to I when I and D request together.
- Re-raising i_req in the cycle after i_done with d_req also pending -> D is granted first (round robin), then I.
